// File: rtl/ssb_arbiter_if.sv
// ssb_arbiter_if: bundles the host-side and device-side bus signals of the
// system-bus arbiter.
//
// Handshake semantics (host side and device side alike): a transfer happens
// in the cycle where req and gnt are both high. A requester holds req and its
// payload (we/be/addr/wdata) stable until it sees gnt. Each transfer produces
// exactly one rvalid pulse (with err/rdata) in a later cycle. Responses come
// back in issue order.
//
// Modports:
//   slave  - the arbiter: consumes host requests, drives the device request
//   master - the environment: drives host requests and device responses
interface ssb_arbiter_if #(
  parameter int NrHosts   = 3,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  // Host side
  logic [NrHosts-1:0]             host_req_i;
  logic [NrHosts-1:0]             host_we_i;
  logic [NrHosts*DataWidth/8-1:0] host_be_i;
  logic [NrHosts*AddrWidth-1:0]   host_addr_i;
  logic [NrHosts*DataWidth-1:0]   host_wdata_i;
  logic [NrHosts-1:0]             host_gnt_o;
  logic [NrHosts-1:0]             host_rvalid_o;
  logic [NrHosts-1:0]             host_err_o;
  logic [DataWidth-1:0]           host_rdata_o;

  // Device side
  logic                           dev_req_o;
  logic                           dev_we_o;
  logic [DataWidth/8-1:0]         dev_be_o;
  logic [AddrWidth-1:0]           dev_addr_o;
  logic [DataWidth-1:0]           dev_wdata_o;
  logic                           dev_gnt_i;
  logic                           dev_rvalid_i;
  logic                           dev_err_i;
  logic [DataWidth-1:0]           dev_rdata_i;

  modport slave (
    input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    output dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i
  );

  modport master (
    output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    input  dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i
  );
endinterface

// File: rtl/ssb_arbiter.sv
// ssb_arbiter: round-robin arbiter sharing one system bus between NrHosts
// hosts (instruction fetch, data, debug SBA). The selected host's request is
// forwarded to the device; the granted host ID is queued in an in-order
// FIFO so each device response is routed back to the host that owns the
// oldest outstanding transaction.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   bus            ssb_arbiter_if.slave (host request/response, device bus)
//   outstanding_o  registered count of in-flight transactions
//   spurious_o     sticky: a device response arrived with nothing outstanding
//
// The control state is the rotating pointer, the ID FIFO and its count; there
// is no FSM. outstanding_o exposes the FIFO occupancy directly.
module ssb_arbiter #(
  parameter int NrHosts        = 3,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  ssb_arbiter_if.slave                         bus,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 spurious_o
);

  localparam int BeWidth  = DataWidth / 8;
  localparam int IdWidth  = $clog2(NrHosts);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdWidth-1:0]  rr_ptr_q;
  logic [IdWidth-1:0]  sel;
  logic [IdWidth-1:0]  rr_next;
  logic [IdWidth-1:0]  head_id;
  logic                any_req;
  logic                not_full;
  logic                handshake;
  logic                pop;
  logic [CntWidth-1:0] count_q;
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic                spurious_q;
  logic [IdWidth-1:0]  id_fifo_q [MaxOutstanding];

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin scan starting at rr_ptr_q; first requester wins.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int i = 0; i < NrHosts; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NrHosts) idx = idx - NrHosts;
      if (!found && bus.host_req_i[IdWidth'(idx)]) begin
        sel   = IdWidth'(idx);
        found = 1'b1;
      end
    end
  end

  assign rr_next  = (sel == IdWidth'(NrHosts - 1)) ? '0 : sel + 1'b1;
  assign any_req  = |bus.host_req_i;
  // The full check uses only the registered count, so a same-cycle rvalid
  // never re-opens the request path combinationally.
  assign not_full = (count_q < CntWidth'(MaxOutstanding));

  // rst_ni gates the combinational outputs so they read zero while reset is
  // asserted, independent of what the hosts are driving.
  assign bus.dev_req_o = rst_ni & any_req & not_full;
  assign handshake     = bus.dev_req_o & bus.dev_gnt_i;
  assign bus.host_gnt_o = handshake ? (NrHosts'(1) << sel) : '0;

  // Payload follows sel whenever anyone requests, even while full.
  always_comb begin
    bus.dev_we_o    = 1'b0;
    bus.dev_be_o    = '0;
    bus.dev_addr_o  = '0;
    bus.dev_wdata_o = '0;
    if (rst_ni && any_req) begin
      for (int k = 0; k < NrHosts; k++) begin
        if (sel == IdWidth'(k)) begin
          bus.dev_we_o    = bus.host_we_i[k];
          bus.dev_be_o    = bus.host_be_i[k*BeWidth +: BeWidth];
          bus.dev_addr_o  = bus.host_addr_i[k*AddrWidth +: AddrWidth];
          bus.dev_wdata_o = bus.host_wdata_i[k*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Response routing: the FIFO head owns the oldest transaction.
  assign head_id           = id_fifo_q[rd_ptr_q];
  assign pop               = rst_ni & bus.dev_rvalid_i & (count_q != '0);
  assign bus.host_rvalid_o = pop ? (NrHosts'(1) << head_id) : '0;
  assign bus.host_err_o    = (pop && bus.dev_err_i) ? (NrHosts'(1) << head_id) : '0;
  assign bus.host_rdata_o  = bus.dev_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      spurious_q <= 1'b0;
      for (int k = 0; k < MaxOutstanding; k++) id_fifo_q[k] <= '0;
    end else begin
      if (handshake) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
        rr_ptr_q            <= rr_next;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (handshake && !pop) count_q <= count_q + 1'b1;
      else if (!handshake && pop) count_q <= count_q - 1'b1;
      if (bus.dev_rvalid_i && (count_q == '0)) spurious_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_ssb_arbiter.sv
// tb_ssb_arbiter: randomized bench for ssb_arbiter. A reference model
// (pointer, outstanding count, queue of owed response IDs) predicts the
// device request, grant and payload every cycle; a separate monitor pops the
// expected-ID queue whenever the DUT presents a host response.
module tb_ssb_arbiter;
  localparam int N  = 3;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssb_arbiter_if #(.NrHosts(N), .AddrWidth(AW), .DataWidth(DW)) bus ();
  logic [CW-1:0] outstanding;
  logic          spurious;

  ssb_arbiter #(
    .NrHosts(N), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .outstanding_o(outstanding),
    .spurious_o   (spurious)
  );

  int checks = 0;
  int errors = 0;

  // Host-side stimulus state
  logic [N-1:0]  req_v = '0;
  logic          h_we    [N];
  logic [BW-1:0] h_be    [N];
  logic [AW-1:0] h_addr  [N];
  logic [DW-1:0] h_wdata [N];

  // Stimulus knobs
  int           req_pct = 0;
  int           gnt_pct = 0;
  int           rv_pct  = 0;
  logic [N-1:0] req_mask = '0;
  bit           force_rv = 1'b0;

  // Reference model
  int         m_rr   = 0;
  int         m_cnt  = 0;
  bit         m_spur = 1'b0;
  logic [7:0] exp_q[$];
  bit         hs_valid  = 1'b0;
  int         hs_id     = 0;
  bit         exp_resp  = 1'b0;

  int p_sel;
  bit p_any, p_found, p_req, p_hs, p_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_bus();
    for (int k = 0; k < N; k++) begin
      bus.host_req_i[k]                = req_v[k];
      bus.host_we_i[k]                 = h_we[k];
      bus.host_be_i[k*BW +: BW]        = h_be[k];
      bus.host_addr_i[k*AW +: AW]      = h_addr[k];
      bus.host_wdata_i[k*DW +: DW]     = h_wdata[k];
    end
  endtask

  task automatic new_payload(input int k);
    h_we[k]    = 1'($urandom_range(1));
    h_be[k]    = BW'($urandom);
    h_addr[k]  = AW'($urandom);
    h_wdata[k] = DW'($urandom);
  endtask

  // Driver: one bus cycle. A host drops its request after its predicted
  // handshake and may raise a fresh one immediately.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs_valid && hs_id == k) req_v[k] = 1'b0;
      if (!req_v[k] && req_mask[k] && ($urandom_range(99) < req_pct)) begin
        req_v[k] = 1'b1;
        new_payload(k);
      end
    end
    bus.dev_gnt_i    = ($urandom_range(99) < gnt_pct);
    bus.dev_rvalid_i = force_rv || ((m_cnt > 0) && ($urandom_range(99) < rv_pct));
    bus.dev_err_i    = 1'($urandom_range(1));
    bus.dev_rdata_i  = DW'($urandom);
    apply_bus();
  endtask

  // Reference model: predicts this cycle's device request and grant from the
  // arbitration rules, then advances its state as the clock edge will.
  always @(negedge clk) begin
    if (rst_n) begin
      p_any   = |req_v;
      p_found = 1'b0;
      p_sel   = 0;
      for (int j = 0; j < N; j++) begin
        if (!p_found && req_v[(m_rr + j) % N]) begin
          p_sel   = (m_rr + j) % N;
          p_found = 1'b1;
        end
      end
      p_req = p_any && (m_cnt < MO);
      p_hs  = p_req && bus.dev_gnt_i;
      check("dev_req", 64'(bus.dev_req_o), 64'(p_req));
      check("host_gnt", 64'(bus.host_gnt_o), p_hs ? (64'(1) << p_sel) : 64'(0));
      check("outstanding", 64'(outstanding), 64'(m_cnt));
      check("spurious", 64'(spurious), 64'(m_spur));
      check("dev_we", 64'(bus.dev_we_o), p_any ? 64'(h_we[p_sel]) : 64'(0));
      check("dev_be", 64'(bus.dev_be_o), p_any ? 64'(h_be[p_sel]) : 64'(0));
      check("dev_addr", 64'(bus.dev_addr_o), p_any ? 64'(h_addr[p_sel]) : 64'(0));
      check("dev_wdata", 64'(bus.dev_wdata_o), p_any ? 64'(h_wdata[p_sel]) : 64'(0));
      p_pop = bus.dev_rvalid_i && (m_cnt > 0);
      if (bus.dev_rvalid_i && m_cnt == 0) m_spur = 1'b1;
      exp_resp = p_pop;
      hs_valid = p_hs;
      hs_id    = p_sel;
      if (p_hs) begin
        exp_q.push_back(8'(p_sel));
        m_rr = (p_sel + 1) % N;
      end
      m_cnt = m_cnt + int'(p_hs) - int'(p_pop);
    end else begin
      exp_resp = 1'b0;
      hs_valid = 1'b0;
    end
  end

  // Response monitor: whenever a host response is owed or shown, the oldest
  // expected ID must own it.
  always @(negedge clk) begin
    logic [7:0] id;
    #2;
    if (rst_n && (exp_resp || bus.host_rvalid_o != '0)) begin
      if (exp_resp && exp_q.size() > 0) begin
        id = exp_q.pop_front();
        check("host_rvalid", 64'(bus.host_rvalid_o), 64'(1) << id);
        check("host_err", 64'(bus.host_err_o), bus.dev_err_i ? (64'(1) << id) : 64'(0));
        check("host_rdata", 64'(bus.host_rdata_o), 64'(bus.dev_rdata_i));
      end else begin
        checks++;
        errors++;
        $display("FAIL host_rvalid: got %b expected no response at %0t",
                 bus.host_rvalid_o, $time);
      end
    end
  end

  task automatic set_knobs(input logic [N-1:0] mask, input int rq, input int gn, input int rv);
    req_mask = mask;
    req_pct  = rq;
    gnt_pct  = gn;
    rv_pct   = rv;
  endtask

  initial begin
    int guard;
    for (int k = 0; k < N; k++) new_payload(k);
    bus.dev_gnt_i    = 1'b1;
    bus.dev_rvalid_i = 1'b0;
    bus.dev_err_i    = 1'b0;
    bus.dev_rdata_i  = '0;
    // Hosts requesting during reset must not leak through.
    req_v = '1;
    apply_bus();
    #2;
    check("rst_dev_req", 64'(bus.dev_req_o), 64'(0));
    check("rst_host_gnt", 64'(bus.host_gnt_o), 64'(0));
    check("rst_dev_addr", 64'(bus.dev_addr_o), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_spurious", 64'(spurious), 64'(0));
    req_v = '0;
    apply_bus();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single host 1, constant grant, response the next cycle.
    set_knobs(3'b010, 100, 100, 100);
    repeat (10) step();

    // All hosts requesting continuously: grants rotate.
    set_knobs(3'b111, 100, 100, 100);
    repeat (30) step();

    // Responses withheld until the FIFO fills, then released.
    set_knobs(3'b111, 100, 100, 0);
    repeat (8) step();
    set_knobs(3'b111, 100, 100, 100);
    repeat (8) step();

    // Drain everything, then a response with nothing outstanding.
    set_knobs(3'b111, 0, 100, 100);
    guard = 0;
    while ((m_cnt != 0 || req_v != '0) && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", m_cnt);
    end
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    repeat (4) step();

    // Random traffic.
    set_knobs(3'b111, 40, 60, 50);
    repeat (2000) step();

    // Reset with transactions outstanding.
    set_knobs(3'b111, 100, 100, 0);
    repeat (8) step();
    @(negedge clk);
    #3;
    bus.dev_rvalid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_dev_req", 64'(bus.dev_req_o), 64'(0));
    check("midrst_host_gnt", 64'(bus.host_gnt_o), 64'(0));
    check("midrst_host_rvalid", 64'(bus.host_rvalid_o), 64'(0));
    check("midrst_outstanding", 64'(outstanding), 64'(0));
    check("midrst_spurious", 64'(spurious), 64'(0));
    check("midrst_dev_wdata", 64'(bus.dev_wdata_o), 64'(0));
    m_rr     = 0;
    m_cnt    = 0;
    m_spur   = 1'b0;
    exp_q.delete();
    hs_valid = 1'b0;
    exp_resp = 1'b0;
    bus.dev_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_knobs(3'b111, 100, 100, 100);
    repeat (20) step();

    @(negedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
